// File: rtl/cables_pkg.sv
// Shared types for the pipeline controller: FSM states, stage indices and
// the control bundle fanned out to the four pipe register instances.
package cables_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } pipe_ctrl_state_t;

  localparam int unsigned PIPE_IF_ID  = 0;
  localparam int unsigned PIPE_ID_EX  = 1;
  localparam int unsigned PIPE_EX_MEM = 2;
  localparam int unsigned PIPE_MEM_WB = 3;

  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] flush;
  } pipe_ctrl_t;

  // Flush always masks enable so a flushed register is never also written.
  function automatic pipe_ctrl_t mk_ctrl(logic pc_en, logic [3:0] en, logic [3:0] flush);
    pipe_ctrl_t c;
    c.pc_en = pc_en;
    c.en    = en & ~flush;
    c.flush = flush;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
module hazard_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  output logic                  load_use
);

  always_comb begin
    load_use = ex_is_load && (ex_rd != '0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) ||
                (id_rs2_used && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline controller: stall/flush arbitration, post-trap
// bubble insertion, saturating stall/flush counters and a stall watchdog.
module pipe_ctrl
  import cables_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned IMEM_LAT   = 1,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WDOG_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_busy,
  input  logic                  ex_redirect,
  input  logic                  mem_wait,
  input  logic                  if_wait,
  input  logic                  trap,
  output logic                  pc_en,
  output logic [3:0]            pipe_en,
  output logic [3:0]            pipe_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic                  watchdog_err
);

  localparam int unsigned BUB_W = (IMEM_LAT < 1) ? 1 : $clog2(IMEM_LAT + 1);
  localparam int unsigned WD_W  = $clog2(WDOG_LIMIT + 1);

  pipe_ctrl_state_t state_q, state_d;
  logic [BUB_W-1:0] bub_q, bub_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             wd_err_q;
  logic             load_use;
  logic             flush_evt;
  pipe_ctrl_t       ctrl;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .load_use    (load_use)
  );

  always_comb begin
    ctrl      = mk_ctrl(1'b1, 4'b1111, 4'b0000);
    flush_evt = 1'b0;
    state_d   = state_q;
    bub_d     = bub_q;

    if (rst) begin
      ctrl = mk_ctrl(1'b0, 4'b0000, 4'b1111);
    end else if (state_q == FLUSH && !trap && !mem_wait) begin
      ctrl = mk_ctrl(1'b1, 4'b1110, 4'b0001);
    end else if (trap) begin
      ctrl      = mk_ctrl(1'b1, 4'b0000, 4'b1111);
      flush_evt = 1'b1;
    end else if (mem_wait) begin
      ctrl = mk_ctrl(1'b0, 4'b0000, 4'b1000);
    end else if (ex_busy) begin
      ctrl = mk_ctrl(1'b0, 4'b1000, 4'b0100);
    end else if (ex_redirect) begin
      ctrl      = mk_ctrl(1'b1, 4'b1100, 4'b0011);
      flush_evt = 1'b1;
    end else if (load_use) begin
      ctrl = mk_ctrl(1'b0, 4'b1100, 4'b0010);
    end else if (if_wait) begin
      ctrl = mk_ctrl(1'b0, 4'b1110, 4'b0001);
    end

    if (!rst) begin
      if (trap) begin
        state_d = FLUSH;
        bub_d   = BUB_W'(IMEM_LAT);
      end else if (state_q == FLUSH) begin
        // Bubble counter runs down even when mem_wait overrides the bubble.
        bub_d = bub_q - BUB_W'(1);
        if (bub_q <= BUB_W'(1)) state_d = RUN;
      end else begin
        state_d = ctrl.pc_en ? RUN : STALL;
      end
    end

    if (ctrl.pc_en)                    wd_d = '0;
    else if (wd_q != WD_W'(WDOG_LIMIT)) wd_d = wd_q + WD_W'(1);
    else                               wd_d = wd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      bub_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wd_q        <= '0;
      wd_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      wd_q    <= wd_d;
      if (!ctrl.pc_en && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && flush_cnt_q != '1)   flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (wd_d == WD_W'(WDOG_LIMIT))        wd_err_q    <= 1'b1;
    end
  end

  always_comb begin
    pc_en        = ctrl.pc_en;
    pipe_en      = ctrl.en;
    pipe_flush   = ctrl.flush;
    stall_cnt    = stall_cnt_q;
    flush_cnt    = flush_cnt_q;
    watchdog_err = wd_err_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (IMEM_LAT=2, WDOG_LIMIT=8) with a 2-bit-counter
// companion instance to observe counter saturation.
module tb_pipe_ctrl;
  import cables_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_is_load, ex_busy, ex_redirect;
  logic       mem_wait, if_wait, trap;
  logic       pc_en, watchdog_err;
  logic [3:0] pipe_en, pipe_flush;
  logic [31:0] stall_cnt, flush_cnt;
  logic       s_pc_en, s_wd;
  logic [3:0] s_en, s_fl;
  logic [1:0] s_stall, s_flush;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_ADDR_W(5), .IMEM_LAT(2), .CNT_W(32), .WDOG_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_busy(ex_busy), .ex_redirect(ex_redirect),
    .mem_wait(mem_wait), .if_wait(if_wait), .trap(trap), .pc_en(pc_en),
    .pipe_en(pipe_en), .pipe_flush(pipe_flush), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .watchdog_err(watchdog_err)
  );

  pipe_ctrl #(.REG_ADDR_W(5), .IMEM_LAT(2), .CNT_W(2), .WDOG_LIMIT(8)) dut_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_busy(ex_busy), .ex_redirect(ex_redirect),
    .mem_wait(mem_wait), .if_wait(if_wait), .trap(trap), .pc_en(s_pc_en),
    .pipe_en(s_en), .pipe_flush(s_fl), .stall_cnt(s_stall),
    .flush_cnt(s_flush), .watchdog_err(s_wd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_is_load = 1'b0;
    ex_busy = 1'b0; ex_redirect = 1'b0; mem_wait = 1'b0; if_wait = 1'b0; trap = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic p, input logic [3:0] e, input logic [3:0] f);
    #1;
    chk({tag, ".pc_en"}, 32'(pc_en), 32'(p));
    chk({tag, ".en"},    32'(pipe_en), 32'(e));
    chk({tag, ".flush"}, 32'(pipe_flush), 32'(f));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    chk_comb("rst", 1'b0, 4'b0000, 4'b1111);
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    cyc();
    do_reset();
    #1;
    chk("rst.stall_cnt", stall_cnt, 32'd0);
    chk("rst.flush_cnt", flush_cnt, 32'd0);
    chk("rst.wdog", 32'(watchdog_err), 32'd0);
    chk("rst.state", 32'(dut.state_q), 32'(RUN));
    chk_comb("idle", 1'b1, 4'b1111, 4'b0000);

    // load-use on rs2
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    chk_comb("lu", 1'b0, 4'b1100, 4'b0010);
    cyc();
    chk("lu.stall_cnt", stall_cnt, 32'd1);
    chk("lu.state", 32'(dut.state_q), 32'(STALL));
    clear_in();
    chk_comb("lu.after", 1'b1, 4'b1111, 4'b0000);
    cyc();
    chk("lu.state_run", 32'(dut.state_q), 32'(RUN));

    // x0 destination never hazards
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    chk_comb("x0", 1'b1, 4'b1111, 4'b0000);
    cyc();
    chk("x0.stall_cnt", stall_cnt, 32'd1);

    // ex_busy x3 then mem_wait x2, from a fresh reset
    do_reset();
    ex_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_comb("busy", 1'b0, 4'b1000, 4'b0100);
      cyc();
    end
    ex_busy = 1'b0; mem_wait = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk_comb("mwait", 1'b0, 4'b0000, 4'b1000);
      cyc();
    end
    chk("mc.stall_cnt", stall_cnt, 32'd5);
    chk("mc.sat_stall", 32'(s_stall), 32'd3);
    chk("mc.state", 32'(dut.state_q), 32'(STALL));
    clear_in();
    chk_comb("mc.after", 1'b1, 4'b1111, 4'b0000);
    cyc();
    chk("mc.state_run", 32'(dut.state_q), 32'(RUN));
    chk("mc.wdog", 32'(watchdog_err), 32'd0);

    // trap beats mem_wait and redirect, then two bubbles
    trap = 1'b1; mem_wait = 1'b1; ex_redirect = 1'b1;
    chk_comb("trap", 1'b1, 4'b0000, 4'b1111);
    cyc();
    chk("trap.flush_cnt", flush_cnt, 32'd1);
    chk("trap.state", 32'(dut.state_q), 32'(FLUSH));
    clear_in();
    chk_comb("bub1", 1'b1, 4'b1110, 4'b0001);
    cyc();
    chk_comb("bub2", 1'b1, 4'b1110, 4'b0001);
    cyc();
    chk("trap.state_run", 32'(dut.state_q), 32'(RUN));
    chk_comb("trap.after", 1'b1, 4'b1111, 4'b0000);
    chk("trap.stall_cnt", stall_cnt, 32'd5);

    // redirect beats load-use and if_wait
    ex_redirect = 1'b1; if_wait = 1'b1;
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    chk_comb("redir", 1'b1, 4'b1100, 4'b0011);
    cyc();
    chk("redir.flush_cnt", flush_cnt, 32'd2);
    chk("redir.sat_flush", 32'(s_flush), 32'd2);
    clear_in();
    if_wait = 1'b1;
    chk_comb("ifw", 1'b0, 4'b1110, 4'b0001);
    cyc();
    clear_in();
    cyc();

    // watchdog: 10 consecutive mem_wait stalls
    mem_wait = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i == 7) chk("wd.before", 32'(watchdog_err), 32'd0);
      if (i == 8) chk("wd.at8", 32'(watchdog_err), 32'd1);
    end
    mem_wait = 1'b0;
    cyc();
    chk("wd.sticky", 32'(watchdog_err), 32'd1);
    chk("wd.stall_cnt", stall_cnt, 32'd16);

    // reset in the middle of a stall
    mem_wait = 1'b1;
    cyc();
    do_reset();
    #1;
    chk("rst2.stall_cnt", stall_cnt, 32'd0);
    chk("rst2.flush_cnt", flush_cnt, 32'd0);
    chk("rst2.wdog", 32'(watchdog_err), 32'd0);
    chk("rst2.state", 32'(dut.state_q), 32'(RUN));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Drives the enable and flush inputs of the four pipe register instances (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Resolves load-use hazards, multi-cycle EX stalls, memory wait states, branch redirects and traps.
- Keeps stall/flush performance counters and a stall watchdog.

Parameters:
- REG_ADDR_W, 5, register-index width.
- IMEM_LAT, 1, number of post-trap bubble cycles covering instruction-memory latency (>=1).
- CNT_W, 32, width of the saturating performance counters.
- WDOG_LIMIT, 1024, consecutive stall cycles before watchdog_err sets.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1  source operand actually read
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
- ex_is_load  in  1  EX instruction is a load
- ex_busy  in  1  multi-cycle EX unit not done
- ex_redirect  in  1  branch mispredict resolved in EX
- mem_wait  in  1  data memory not ready
- if_wait  in  1  instruction memory not ready
- trap  in  1  exception taken in MEM
- pc_en  out  1  PC update enable
- pipe_en  out  4  per-register enable; bit0=IF/ID … bit3=MEM/WB
- pipe_flush  out  4  per-register flush, same indexing
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  redirect + trap events
- watchdog_err  out  1  sticky stall-timeout flag

Behaviour:
- Outputs are combinational from inputs and state (zero-latency Mealy). Counters, state and watchdog_err are registered.
- Flush has priority over enable in each pipe register. Regardless, whenever pipe_flush[i]=1 this block drives pipe_en[i]=0.
- While rst=1:
  - pc_en=0, pipe_en=0000, pipe_flush=1111.
  - Next edge: state=RUN, counters=0, watchdog_err=0, bubble counter=0.
- load_use = ex_is_load & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Per-cycle priority (first match wins), in RUN/STALL:
  1. trap: pc_en=1, pipe_flush=1111. Next state FLUSH, bubble counter=IMEM_LAT. flush_cnt++.
  2. mem_wait: pc_en=0, pipe_en=0000, pipe_flush=1000 (no repeated writeback).
  3. ex_busy: pc_en=0, pipe_en=1000, pipe_flush=0100.
  4. ex_redirect: pc_en=1, pipe_flush=0011, pipe_en=1100. flush_cnt++.
  5. load_use: pc_en=0, pipe_flush=0010, pipe_en=1100 (IF/ID held).
  6. if_wait: pc_en=0, pipe_flush=0001, pipe_en=1110.
  7. none: pc_en=1, pipe_en=1111, pipe_flush=0000.
- FSM:
  - RUN -> STALL when the selected case has pc_en=0.
  - STALL -> RUN when pc_en=1.
  - FLUSH: decrement the bubble counter each cycle, return to RUN when it reaches 0.
  - In FLUSH, if there is no trap and no mem_wait: pc_en=1, pipe_flush=0001, pipe_en=1110. Otherwise apply the normal priority list.
  - A trap in FLUSH reloads the bubble counter to IMEM_LAT.
- Redirect is lower priority than mem_wait/ex_busy. The EX stage holds it asserted until consumed, so it is never lost.
- stall_cnt increments on every non-reset cycle with pc_en=0 and saturates at all-ones. flush_cnt saturates likewise.
- Watchdog:
  - Consecutive-stall counter increments while pc_en=0 and clears when pc_en=1.
  - When it reaches WDOG_LIMIT, watchdog_err=1 and stays set until rst.
  - The watchdog does not alter pipeline control.

Decomposition:
- In cables_pkg:
  - pipe_ctrl_state_t enum {RUN, STALL, FLUSH}.
  - Stage index constants PIPE_IF_ID=0, PIPE_ID_EX=1, PIPE_EX_MEM=2, PIPE_MEM_WB=3.
  - pipe_ctrl_t struct {pc_en, en[4], flush[4]} for fan-out to the pipe instances.
- One combinational sub-module: hazard_detect (produces load_use).

Test Plan:
- load_use: ex_is_load=1, ex_rd=5, id_rs2=5, id_rs2_used=1 for one cycle -> pc_en=0, pipe_flush=0010, pipe_en=1100, stall_cnt 0->1; next cycle with inputs clear -> pipe_en=1111.
- ex_rd=0 with a load and id_rs1=0 used -> no stall, pipe_en=1111.
- ex_busy held 3 cycles, then mem_wait 2 cycles -> pc_en=0 for 5 cycles; flush 0100 then 1000; stall_cnt=5; state STALL then RUN.
- trap with IMEM_LAT=2 concurrent with mem_wait and ex_redirect -> trap wins: pipe_flush=1111, pc_en=1; next 2 cycles pipe_flush=0001; flush_cnt=1; back in RUN.
- ex_redirect concurrent with load_use and if_wait -> pipe_flush=0011, pc_en=1, flush_cnt++.
- WDOG_LIMIT=8, mem_wait held 10 cycles -> watchdog_err=1 after the 8th stall cycle, stays 1 after mem_wait drops. rst mid-stall -> next cycle all counters 0, watchdog_err=0, state RUN.
